// File: rtl/mem_access_ctrl.sv
// ---------------------------------------------------------------------------
// mem_access_ctrl
//
// Memory-stage access controller. Consumes the memory operation held in the
// execute/memory pipeline register, runs the data-bus request/response
// handshake, formats store lanes/strobes, extends load data and raises stallM
// to freeze the execute/memory register until the access has completed.
//
// Ports
//   clk, reset          clock, asynchronous active-high reset
//   op_*                held memory operation (valid, load/store, size,
//                       unsigned, effective address, right-aligned store data)
//   dreq_*              data-bus request (valid, addr, size, strobe, data)
//   dresp_*             data-bus response (addr accepted, data done, data)
//   stallM              hold the execute/memory register
//   mem_done            one-cycle completion pulse
//   load_data           extended load result, valid while mem_done=1
//   misalign            current operation is misaligned (combinational)
// ---------------------------------------------------------------------------
module mem_access_ctrl #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                op_valid,
    input  logic                op_load,
    input  logic                op_store,
    input  logic [1:0]          op_size,
    input  logic                op_unsigned,
    input  logic [ADDR_W-1:0]   op_addr,
    input  logic [DATA_W-1:0]   op_wdata,
    output logic                dreq_valid,
    output logic [ADDR_W-1:0]   dreq_addr,
    output logic [1:0]          dreq_size,
    output logic [DATA_W/8-1:0] dreq_strobe,
    output logic [DATA_W-1:0]   dreq_data,
    input  logic                dresp_addr_ok,
    input  logic                dresp_data_ok,
    input  logic [DATA_W-1:0]   dresp_data,
    output logic                stallM,
    output logic                mem_done,
    output logic [DATA_W-1:0]   load_data,
    output logic                misalign
);

    localparam int STRB_W = DATA_W / 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t              stateReg;
    state_t              stateNext;
    logic [DATA_W-1:0]   capturedReg;
    logic                captureEn;

    logic                memOp;
    logic                misaligned;
    logic                issueOk;
    logic [5:0]          laneShift;
    logic [3:0]          byteLo;
    logic [3:0]          byteCnt;
    logic [STRB_W-1:0]   strobeBits;
    logic [DATA_W-1:0]   loadWord;
    logic [DATA_W-1:0]   loadExt;

    logic                reqValidComb;
    logic                stallComb;
    logic                doneComb;

    // -----------------------------------------------------------------------
    // Operation decode and alignment
    // -----------------------------------------------------------------------
    assign memOp = op_valid & (op_load | op_store);

    always_comb begin
        misaligned = 1'b0;
        case (op_size)
            2'd0:    misaligned = 1'b0;
            2'd1:    misaligned = op_addr[0];
            2'd2:    misaligned = |op_addr[1:0];
            default: misaligned = |op_addr[2:0];
        endcase
    end

    assign misalign = memOp & misaligned;
    assign issueOk  = memOp & ~misaligned;

    // -----------------------------------------------------------------------
    // Lane formatting
    // -----------------------------------------------------------------------
    assign laneShift = {op_addr[2:0], 3'b000};
    assign byteLo    = {1'b0, op_addr[2:0]};
    assign byteCnt   = 4'(1 << op_size);

    // A byte lane is written when it falls in [offset, offset+bytes). Lanes
    // past the top of the word drop out, which is the 8-bit truncation of
    // the shifted mask.
    generate
        for (genvar gi = 0; gi < STRB_W; gi++) begin : gen_strobe
            assign strobeBits[gi] = op_store
                                  && (4'(gi) >= byteLo)
                                  && (4'(gi) <  (byteLo + byteCnt));
        end
    endgenerate

    assign dreq_addr   = op_addr;
    assign dreq_size   = op_size;
    assign dreq_strobe = memOp ? strobeBits : '0;
    assign dreq_data   = memOp ? (op_wdata << laneShift) : '0;

    // -----------------------------------------------------------------------
    // FSM state register and captured read word
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stateReg    <= IDLE;
            capturedReg <= '0;
        end else begin
            stateReg <= stateNext;
            if (captureEn) begin
                capturedReg <= dresp_data;
            end
        end
    end

    // -----------------------------------------------------------------------
    // FSM next state and handshake outputs
    // -----------------------------------------------------------------------
    always_comb begin
        stateNext    = stateReg;
        reqValidComb = 1'b0;
        stallComb    = 1'b0;
        doneComb     = 1'b0;
        captureEn    = 1'b0;

        case (stateReg)
            IDLE: begin
                // The request goes out in the same cycle the op appears, so a
                // bus that answers immediately costs only one stall cycle.
                if (issueOk) begin
                    reqValidComb = 1'b1;
                    stallComb    = 1'b1;
                    if (dresp_addr_ok && dresp_data_ok) begin
                        captureEn = 1'b1;
                        stateNext = DONE;
                    end else if (dresp_addr_ok) begin
                        stateNext = WAIT;
                    end else begin
                        stateNext = REQ;
                    end
                end
            end

            REQ: begin
                reqValidComb = 1'b1;
                stallComb    = 1'b1;
                if (dresp_addr_ok && dresp_data_ok) begin
                    captureEn = 1'b1;
                    stateNext = DONE;
                end else if (dresp_addr_ok) begin
                    stateNext = WAIT;
                end
            end

            WAIT: begin
                stallComb = 1'b1;
                if (dresp_data_ok) begin
                    captureEn = 1'b1;
                    stateNext = DONE;
                end
            end

            default: begin
                // DONE: stall released so the pipeline register advances on
                // this edge; the forced return to IDLE is the one-cycle bubble.
                doneComb  = 1'b1;
                stateNext = IDLE;
            end
        endcase
    end

    // While reset is held the controller is silent even if a memory op is
    // still presented, otherwise IDLE would re-issue it during reset.
    assign dreq_valid = reqValidComb & ~reset;
    assign stallM     = stallComb & ~reset;
    assign mem_done   = doneComb & ~reset;

    // -----------------------------------------------------------------------
    // Load extraction: op inputs are still held during DONE
    // -----------------------------------------------------------------------
    assign loadWord = capturedReg >> laneShift;

    always_comb begin
        loadExt = '0;
        case (op_size)
            2'd0: loadExt = op_unsigned ? {56'd0, loadWord[7:0]}
                                        : {{56{loadWord[7]}}, loadWord[7:0]};
            2'd1: loadExt = op_unsigned ? {48'd0, loadWord[15:0]}
                                        : {{48{loadWord[15]}}, loadWord[15:0]};
            2'd2: loadExt = op_unsigned ? {32'd0, loadWord[31:0]}
                                        : {{32{loadWord[31]}}, loadWord[31:0]};
            default: loadExt = loadWord;
        endcase
    end

    assign load_data = (doneComb && op_load && !reset) ? loadExt : '0;

endmodule

// File: tb/tb_mem_access_ctrl.sv
module tb_mem_access_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        op_valid = 1'b0;
    logic        op_load = 1'b0;
    logic        op_store = 1'b0;
    logic [1:0]  op_size = 2'd0;
    logic        op_unsigned = 1'b0;
    logic [63:0] op_addr = 64'd0;
    logic [63:0] op_wdata = 64'd0;
    logic        dreq_valid;
    logic [63:0] dreq_addr;
    logic [1:0]  dreq_size;
    logic [7:0]  dreq_strobe;
    logic [63:0] dreq_data;
    logic        dresp_addr_ok = 1'b0;
    logic        dresp_data_ok = 1'b0;
    logic [63:0] dresp_data = 64'd0;
    logic        stallM;
    logic        mem_done;
    logic [63:0] load_data;
    logic        misalign;

    int checks = 0;
    int errors = 0;

    mem_access_ctrl #(.ADDR_W(64), .DATA_W(64)) dut (
        .clk(clk), .reset(reset),
        .op_valid(op_valid), .op_load(op_load), .op_store(op_store),
        .op_size(op_size), .op_unsigned(op_unsigned),
        .op_addr(op_addr), .op_wdata(op_wdata),
        .dreq_valid(dreq_valid), .dreq_addr(dreq_addr), .dreq_size(dreq_size),
        .dreq_strobe(dreq_strobe), .dreq_data(dreq_data),
        .dresp_addr_ok(dresp_addr_ok), .dresp_data_ok(dresp_data_ok),
        .dresp_data(dresp_data),
        .stallM(stallM), .mem_done(mem_done), .load_data(load_data),
        .misalign(misalign)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // ---------------- reference model ----------------
    function automatic logic [63:0] ref_load(input logic [63:0] word, input logic [1:0] sz,
                                             input logic [63:0] addr, input bit uns);
        int unsigned nbytes = 1 << sz;
        logic [63:0] mask = (nbytes == 8) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (8 * nbytes)) - 64'd1);
        logic [63:0] v = (word >> (8 * addr[2:0])) & mask;
        if (!uns && v[8 * nbytes - 1]) v = v | ~mask;
        return v;
    endfunction

    function automatic logic [7:0] ref_strobe(input bit st, input logic [1:0] sz, input logic [63:0] addr);
        int unsigned m = ((1 << (1 << sz)) - 1) << addr[2:0];
        return st ? m[7:0] : 8'd0;
    endfunction

    function automatic bit ref_misaligned(input logic [1:0] sz, input logic [63:0] addr);
        return (addr % (64'd1 << sz)) != 0;
    endfunction

    task automatic set_idle();
        op_valid = 0; op_load = 0; op_store = 0;
        dresp_addr_ok = 0; dresp_data_ok = 0;
    endtask

    // One aligned access: addr_ok after aDly request cycles, data_ok dDly cycles later.
    task automatic run_txn(input string name, input bit ld, input logic [1:0] sz, input bit uns,
                           input logic [63:0] addr, input logic [63:0] wdata,
                           input logic [63:0] rdata, input int aDly, input int dDly);
        int doneK = aDly + dDly + 1;
        logic [63:0] expLoad = ld ? ref_load(rdata, sz, addr, uns) : 64'd0;
        logic [7:0]  expStrb = ref_strobe(!ld, sz, addr);
        logic [63:0] expData = wdata << (8 * addr[2:0]);
        int stallCycles = 0;
        @(posedge clk); #1;
        op_valid = 1; op_load = ld; op_store = !ld; op_size = sz;
        op_unsigned = uns; op_addr = addr; op_wdata = wdata;
        for (int k = 0; k <= doneK; k++) begin
            if (k > 0) begin @(posedge clk); #1; end
            dresp_addr_ok = (k == aDly);
            dresp_data_ok = (k == aDly + dDly);
            dresp_data    = dresp_data_ok ? rdata : {$urandom, $urandom};
            @(negedge clk);
            if (stallM) stallCycles++;
            checks++; if (dreq_valid !== (k <= aDly)) begin errors++; $display("FAIL %s dreq_valid k=%0d got=%b exp=%b", name, k, dreq_valid, k <= aDly); end
            checks++; if (stallM !== (k < doneK)) begin errors++; $display("FAIL %s stallM k=%0d got=%b exp=%b", name, k, stallM, k < doneK); end
            checks++; if (mem_done !== (k == doneK)) begin errors++; $display("FAIL %s mem_done k=%0d got=%b exp=%b", name, k, mem_done, k == doneK); end
            if (k <= aDly) begin
                checks++; if (dreq_addr !== addr) begin errors++; $display("FAIL %s dreq_addr k=%0d got=%h exp=%h", name, k, dreq_addr, addr); end
                checks++; if (dreq_strobe !== expStrb) begin errors++; $display("FAIL %s dreq_strobe got=%h exp=%h", name, dreq_strobe, expStrb); end
                if (!ld) begin
                    checks++; if (dreq_data !== expData) begin errors++; $display("FAIL %s dreq_data got=%h exp=%h", name, dreq_data, expData); end
                end
            end
            if (k == doneK) begin
                checks++; if (load_data !== expLoad) begin errors++; $display("FAIL %s load_data got=%h exp=%h", name, load_data, expLoad); end
            end
        end
        dresp_addr_ok = 0; dresp_data_ok = 0;
        $display("txn %s %s size=%0d addr=%h stall=%0d load_data=%h", name, ld ? "LD" : "ST", sz, addr, stallCycles, load_data);
    endtask

    task automatic run_misaligned(input string name, input bit ld, input logic [1:0] sz, input logic [63:0] addr);
        @(posedge clk); #1;
        op_valid = 1; op_load = ld; op_store = !ld; op_size = sz; op_addr = addr;
        op_wdata = {$urandom, $urandom};
        for (int k = 0; k < 3; k++) begin
            if (k > 0) begin @(posedge clk); #1; end
            dresp_addr_ok = $urandom_range(0, 1); dresp_data_ok = $urandom_range(0, 1);
            @(negedge clk);
            checks++; if (misalign !== 1'b1) begin errors++; $display("FAIL %s misalign got=%b exp=1", name, misalign); end
            checks++; if (dreq_valid !== 1'b0) begin errors++; $display("FAIL %s dreq_valid got=%b exp=0", name, dreq_valid); end
            checks++; if (stallM !== 1'b0) begin errors++; $display("FAIL %s stallM got=%b exp=0", name, stallM); end
            checks++; if (mem_done !== 1'b0) begin errors++; $display("FAIL %s mem_done got=%b exp=0", name, mem_done); end
        end
        dresp_addr_ok = 0; dresp_data_ok = 0;
        $display("txn %s misaligned size=%0d addr=%h", name, sz, addr);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        #3;
        checks++; if ({dreq_valid, stallM, mem_done} !== 3'b000) begin errors++; $display("FAIL reset outputs got=%b exp=000", {dreq_valid, stallM, mem_done}); end
        checks++; if (load_data !== 64'd0) begin errors++; $display("FAIL reset load_data got=%h exp=0", load_data); end
        @(posedge clk); #1 reset = 0;
        @(negedge clk);
        checks++; if ({dreq_valid, stallM, mem_done} !== 3'b000) begin errors++; $display("FAIL post_reset outputs got=%b exp=000", {dreq_valid, stallM, mem_done}); end
        $display("txn reset done");
    endtask

    task automatic test_directed();
        run_txn("load64", 1, 2'd3, 0, 64'h8000_1000, 64'd0, 64'hDEADBEEF_CAFEF00D, 0, 3);
        run_txn("store_b", 0, 2'd0, 0, 64'h8000_1005, 64'hAB, 64'd0, 0, 0);
        run_txn("lh_signed", 1, 2'd1, 0, 64'h8000_2006, 64'd0, 64'h8123_0000_0000_0000, 1, 1);
        run_txn("lh_unsigned", 1, 2'd1, 1, 64'h8000_2006, 64'd0, 64'h8123_0000_0000_0000, 0, 2);
        run_txn("backpressure", 1, 2'd2, 0, 64'h8000_3004, 64'd0, 64'h8765_4321_0000_0000, 5, 0);
        run_txn("store_w", 0, 2'd2, 0, 64'h8000_3004, 64'h1122_3344, 64'd0, 2, 2);
        run_misaligned("mis_w", 1, 2'd2, 64'h8000_4002);
    endtask

    task automatic test_idle_ops();
        @(posedge clk); #1;
        set_idle(); op_load = 1; op_valid = 0; dresp_data_ok = 1; dresp_data = 64'h55;
        @(negedge clk);
        checks++; if ({dreq_valid, stallM, mem_done, misalign} !== 4'b0000) begin errors++; $display("FAIL invalid_op outputs got=%b exp=0000", {dreq_valid, stallM, mem_done, misalign}); end
        @(posedge clk); #1;
        op_valid = 1; op_load = 0; op_store = 0; op_addr = 64'h3; op_size = 2'd3; dresp_data_ok = 0;
        @(negedge clk);
        checks++; if ({dreq_valid, stallM, mem_done, misalign} !== 4'b0000) begin errors++; $display("FAIL nonmem_op outputs got=%b exp=0000", {dreq_valid, stallM, mem_done, misalign}); end
        checks++; if (dreq_strobe !== 8'd0) begin errors++; $display("FAIL nonmem_op strobe got=%h exp=0", dreq_strobe); end
        $display("txn idle_ops stray data_ok ignored");
    endtask

    task automatic test_back_to_back();
        // Consecutive accesses with no idle cycle between them in the op stream.
        for (int i = 0; i < 40; i++) begin
            logic [1:0]  sz = 2'($urandom_range(0, 3));
            logic [63:0] addr = {$urandom, $urandom};
            bit          ld = $urandom_range(0, 1);
            if ($urandom_range(0, 3) != 0) addr = addr & ~((64'd1 << sz) - 64'd1);
            if (ref_misaligned(sz, addr))
                run_misaligned($sformatf("rand%0d", i), ld, sz, addr);
            else
                run_txn($sformatf("rand%0d", i), ld, sz, bit'($urandom_range(0, 1)), addr,
                        {$urandom, $urandom}, {$urandom, $urandom},
                        $urandom_range(0, 3), $urandom_range(0, 3));
        end
    endtask

    task automatic test_reset_in_wait();
        @(posedge clk); #1;
        set_idle();
        op_valid = 1; op_load = 1; op_size = 2'd3; op_addr = 64'h9000_0000; dresp_addr_ok = 1;
        @(posedge clk); #1 dresp_addr_ok = 0;
        @(negedge clk);
        checks++; if (stallM !== 1'b1) begin errors++; $display("FAIL wait_stall got=%b exp=1", stallM); end
        #2 reset = 1;
        #1;
        checks++; if ({dreq_valid, stallM, mem_done} !== 3'b000) begin errors++; $display("FAIL reset_in_wait outputs got=%b exp=000", {dreq_valid, stallM, mem_done}); end
        op_valid = 0; op_load = 0;
        @(posedge clk); #1 reset = 0;
        @(posedge clk); #1 dresp_data_ok = 1; dresp_data = 64'h1234;
        @(negedge clk);
        checks++; if ({stallM, mem_done} !== 2'b00) begin errors++; $display("FAIL late_data_ok cycle got=%b exp=00", {stallM, mem_done}); end
        @(posedge clk); #1 dresp_data_ok = 0;
        @(negedge clk);
        checks++; if (mem_done !== 1'b0) begin errors++; $display("FAIL late_data_ok mem_done got=%b exp=0", mem_done); end
        $display("txn reset_in_wait late response ignored");
        run_txn("after_reset", 1, 2'd0, 0, 64'h9000_0007, 64'd0, 64'hF000_0000_0000_0000, 0, 0);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_idle_ops();
        test_back_to_back();
        test_reset_in_wait();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
